// File: rtl/wb_pkg.sv
// Shared definitions for the writeback unit: load funct3 encodings, FSM state
// type and default widths.
package wb_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned DATA_WIDTH_DEF = 64;

    // Load size/sign encodings carried in funct3.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_unit_if.sv
// Execute / memory-response / decode / register-file signals of the writeback
// unit. Optional bypass signals exist only when WB_BYPASS_EN is defined.
interface wb_unit_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic [ADDR_WIDTH-1:0] ex_rd;
    logic                  ex_wen;
    logic                  ex_is_load;
    logic [2:0]            ex_funct3;
    logic [2:0]            ex_addr_lo;
    logic [DATA_WIDTH-1:0] ex_result;
    logic                  mem_rvalid;
    logic [63:0]           mem_rdata;
    logic [ADDR_WIDTH-1:0] id_rs1;
    logic [ADDR_WIDTH-1:0] id_rs2;
    logic                  id_hazard;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_rd;
    logic [DATA_WIDTH-1:0] rf_data;
`ifdef WB_BYPASS_EN
    logic [DATA_WIDTH-1:0] id_fwd1;
    logic [DATA_WIDTH-1:0] id_fwd2;
    logic                  id_fwd1_sel;
    logic                  id_fwd2_sel;

    modport master (
        output ex_valid, ex_rd, ex_wen, ex_is_load, ex_funct3, ex_addr_lo, ex_result,
        output mem_rvalid, mem_rdata, id_rs1, id_rs2,
        input  ex_ready, id_hazard, rf_wen, rf_rd, rf_data,
        input  id_fwd1, id_fwd2, id_fwd1_sel, id_fwd2_sel
    );
    modport slave (
        input  ex_valid, ex_rd, ex_wen, ex_is_load, ex_funct3, ex_addr_lo, ex_result,
        input  mem_rvalid, mem_rdata, id_rs1, id_rs2,
        output ex_ready, id_hazard, rf_wen, rf_rd, rf_data,
        output id_fwd1, id_fwd2, id_fwd1_sel, id_fwd2_sel
    );
`else
    modport master (
        output ex_valid, ex_rd, ex_wen, ex_is_load, ex_funct3, ex_addr_lo, ex_result,
        output mem_rvalid, mem_rdata, id_rs1, id_rs2,
        input  ex_ready, id_hazard, rf_wen, rf_rd, rf_data
    );
    modport slave (
        input  ex_valid, ex_rd, ex_wen, ex_is_load, ex_funct3, ex_addr_lo, ex_result,
        input  mem_rvalid, mem_rdata, id_rs1, id_rs2,
        output ex_ready, id_hazard, rf_wen, rf_rd, rf_data
    );
`endif
endinterface

// File: rtl/load_extend.sv
// Combinational load data alignment and size/sign extension. Shared with the
// future store/AMO paths.
module load_extend
    import wb_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [63:0] ext
);

    logic [63:0] shifted;

    // Bring the addressed byte to bit 0, then extend by access size/sign.
    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_LB:   ext = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   ext = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   ext = {{32{shifted[31]}}, shifted[31:0]};
            F3_LBU:  ext = {56'b0, shifted[7:0]};
            F3_LHU:  ext = {48'b0, shifted[15:0]};
            F3_LWU:  ext = {32'b0, shifted[31:0]};
            default: ext = shifted; // LD and the unused 3'b111 encoding
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage feeding the integer register file. Accepts ALU results and
// loads from execute, waits for the load response, extends it, and drives the
// register-file write port. A busy bit per register flags pending load writes
// to decode. Optional macro: WB_BYPASS_EN adds forwarding of the uncommitted
// register-file write to decode.
module wb_unit
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input logic     clk,
    input logic     rst_n,
    wb_unit_if.slave bus
);

    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    wb_state_t             state_q;
    logic [NREG-1:0]       busy_q;
    logic [ADDR_WIDTH-1:0] ld_rd_q;
    logic                  ld_wen_q;
    logic [2:0]            ld_funct3_q;
    logic [2:0]            ld_addr_lo_q;
    logic                  rf_wen_q;
    logic [ADDR_WIDTH-1:0] rf_rd_q;
    logic [DATA_WIDTH-1:0] rf_data_q;
    logic [63:0]           ld_ext;

    load_extend u_load_extend (
        .rdata   (bus.mem_rdata),
        .addr_lo (ld_addr_lo_q),
        .funct3  (ld_funct3_q),
        .ext     (ld_ext)
    );

    // FSM, busy scoreboard and registered register-file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= '0;
            ld_rd_q      <= '0;
            ld_wen_q     <= 1'b0;
            ld_funct3_q  <= 3'b000;
            ld_addr_lo_q <= 3'b000;
            rf_wen_q     <= 1'b0;
            rf_rd_q      <= '0;
            rf_data_q    <= '0;
        end else begin
            rf_wen_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ex_valid) begin
                        if (bus.ex_is_load) begin
                            ld_rd_q      <= bus.ex_rd;
                            ld_wen_q     <= bus.ex_wen;
                            ld_funct3_q  <= bus.ex_funct3;
                            ld_addr_lo_q <= bus.ex_addr_lo;
                            if (bus.ex_wen && bus.ex_rd != '0) begin
                                busy_q[bus.ex_rd] <= 1'b1;
                            end
                            state_q <= WAIT_LOAD;
                        end else begin
                            rf_wen_q  <= bus.ex_wen && (bus.ex_rd != '0);
                            rf_rd_q   <= bus.ex_rd;
                            rf_data_q <= bus.ex_result;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (bus.mem_rvalid) begin
                        rf_wen_q        <= ld_wen_q && (ld_rd_q != '0);
                        rf_rd_q         <= ld_rd_q;
                        rf_data_q       <= DATA_WIDTH'(ld_ext);
                        busy_q[ld_rd_q] <= 1'b0;
                        state_q         <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ex_ready = (state_q == IDLE);
    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_rd    = rf_rd_q;
    assign bus.rf_data  = rf_data_q;

`ifdef WB_BYPASS_EN
    // Forward the uncommitted write; hazard then only covers pending loads.
    always_comb begin
        bus.id_fwd1_sel = rf_wen_q && (rf_rd_q == bus.id_rs1) && (bus.id_rs1 != '0);
        bus.id_fwd2_sel = rf_wen_q && (rf_rd_q == bus.id_rs2) && (bus.id_rs2 != '0);
        bus.id_fwd1     = rf_data_q;
        bus.id_fwd2     = rf_data_q;
        bus.id_hazard   = ((bus.id_rs1 != '0) && busy_q[bus.id_rs1]) ||
                          ((bus.id_rs2 != '0) && busy_q[bus.id_rs2]);
    end
`else
    // Operand is stale if a load is pending or a write has not committed yet.
    always_comb begin
        bus.id_hazard =
            ((bus.id_rs1 != '0) && (busy_q[bus.id_rs1] || (rf_wen_q && rf_rd_q == bus.id_rs1))) ||
            ((bus.id_rs2 != '0) && (busy_q[bus.id_rs2] || (rf_wen_q && rf_rd_q == bus.id_rs2)));
    end
`endif

`ifndef SYNTHESIS
    // A response while idle has no owner and is dropped; note it in simulation.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == IDLE && bus.mem_rvalid) begin
            $warning("wb_unit: mem_rvalid while idle, dropped");
        end
    end
`endif

endmodule
